// File: rtl/dm_load_unit_pkg.sv
// Shared address map and load-select codes for the M-stage load path.
package dm_load_unit_pkg;

    localparam logic [31:0] START_ADDR_DM  = 32'h0000_0000;
    localparam logic [31:0] END_ADDR_DM    = 32'h0000_2FFF;
    localparam logic [31:0] START_ADDR_TC1 = 32'h0000_7F00;
    localparam logic [31:0] END_ADDR_TC1   = 32'h0000_7F0B;
    localparam logic [31:0] START_ADDR_TC2 = 32'h0000_7F10;
    localparam logic [31:0] END_ADDR_TC2   = 32'h0000_7F1B;
    localparam logic [31:0] START_ADDR_INT = 32'h0000_7F20;
    localparam logic [31:0] END_ADDR_INT   = 32'h0000_7F23;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/dm_load_unit_ext.sv
// Byte/half select and sign/zero extension of a returned read word.
module dm_load_unit_ext
    import dm_load_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  sel,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = rdata[8*gi +: 8];
    end

    assign byte_val = lanes[offset];
    assign half_val = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (sel)
            LD_H:    data = {{16{half_val[15]}}, half_val};
            LD_HU:   data = {16'h0000, half_val};
            LD_B:    data = {{24{byte_val[7]}}, byte_val};
            LD_BU:   data = {24'h00_0000, byte_val};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// M-stage load unit: AdEL detection, single-outstanding read issue, response wait and extension.
module dm_load_unit
    import dm_load_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] addr,
    input  logic [2:0]  load_sel,
    input  logic        add_ovf,
    input  logic        int_req,
    output logic        bus_ren,
    output logic [31:0] bus_addr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    output logic        stall,
    output logic        adel,
    output logic [31:0] ld_data,
    output logic        ld_valid
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [31:0] ext_data;

    logic mapped, misalign, narrow_io, reserved_sel;

    always_comb begin
        mapped = in_range(addr, START_ADDR_DM, END_ADDR_DM)
               | in_range(addr, START_ADDR_TC1, END_ADDR_TC1)
               | in_range(addr, START_ADDR_TC2, END_ADDR_TC2)
               | in_range(addr, START_ADDR_INT, END_ADDR_INT);
        case (load_sel)
            LD_W:         misalign = (addr[1:0] != 2'b00);
            LD_H, LD_HU:  misalign = addr[0];
            default:      misalign = 1'b0;
        endcase
        // Peripheral registers only support full-word access.
        narrow_io    = (load_sel != LD_W) && (addr >= START_ADDR_TC1) && mapped;
        reserved_sel = (load_sel > LD_BU);
        adel = req_valid & (add_ovf | misalign | ~mapped | narrow_io | reserved_sel);
    end

    dm_load_unit_ext u_ext (
        .rdata  (bus_rdata),
        .offset (off_q),
        .sel    (sel_q),
        .data   (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        sel_d     = sel_q;
        ld_data_d = ld_data_q;
        bus_ren   = 1'b0;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !adel && !int_req) begin
                    bus_ren = 1'b1;
                    stall   = 1'b1;
                    off_d   = addr[1:0];
                    sel_d   = load_sel;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (int_req) begin
                    // A response arriving with the flush is the drained one.
                    state_d = bus_rvalid ? S_IDLE : S_DRAIN;
                end else if (bus_rvalid) begin
                    ld_data_d = ext_data;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                stall = req_valid;
                if (bus_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            off_q     <= 2'b00;
            sel_q     <= 3'b000;
            ld_data_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            sel_q     <= sel_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign bus_addr = {addr[31:2], 2'b00};
    assign ld_data  = ld_data_q;
    assign ld_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed and randomized checks of dm_load_unit against an address-rule / shift-based model.
module tb_dm_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] addr;
    logic [2:0]  load_sel;
    logic        add_ovf;
    logic        int_req;
    logic        bus_ren;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        stall;
    logic        adel;
    logic [31:0] ld_data;
    logic        ld_valid;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_data = 32'h0;

    always #5 clk = ~clk;

    dm_load_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .addr       (addr),
        .load_sel   (load_sel),
        .add_ovf    (add_ovf),
        .int_req    (int_req),
        .bus_ren    (bus_ren),
        .bus_addr   (bus_addr),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .stall      (stall),
        .adel       (adel),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_adel(input logic [31:0] a, input logic [2:0] sel,
                                        input logic ovf);
        bit mapped, aligned, is_io;
        mapped  = (a <= 32'h2FFF) || (a >= 32'h7F00 && a <= 32'h7F0B)
               || (a >= 32'h7F10 && a <= 32'h7F1B) || (a >= 32'h7F20 && a <= 32'h7F23);
        is_io   = a >= 32'h7F00;
        aligned = (sel == 3'd0) ? (a % 4 == 0) :
                  (sel == 3'd1 || sel == 3'd2) ? (a % 2 == 0) : 1'b1;
        return ovf || !mapped || !aligned || (sel > 3'd4) || (sel != 3'd0 && is_io);
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] sel, input logic [1:0] off,
                                              input logic [31:0] rdata);
        logic [31:0] sh;
        logic signed [15:0] h;
        logic signed [7:0] b;
        sh = rdata >> (8 * off);
        h  = sh[15:0];
        b  = sh[7:0];
        case (sel)
            3'd1:    return 32'(h);
            3'd2:    return {16'h0, sh[15:0]};
            3'd3:    return 32'(b);
            3'd4:    return {24'h0, sh[7:0]};
            default: return rdata;
        endcase
    endfunction

    // One load from presentation in M through the W-side pulse; k = response latency.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] sel,
                           input logic ovf, input int k, input logic [31:0] rdata);
        logic e_adel;
        int   stall_cycles;
        e_adel = model_adel(a, sel, ovf);
        @(posedge clk); #1;
        req_valid = 1'b1; addr = a; load_sel = sel; add_ovf = ovf;
        @(negedge clk);
        check({tag, ".adel"}, 32'(adel), 32'(e_adel));
        if (e_adel) begin
            check({tag, ".ren"}, 32'(bus_ren), 32'd0);
            check({tag, ".stall"}, 32'(stall), 32'd0);
            $display("load %s addr=%h sel=%0d ovf=%0d -> adel", tag, a, sel, ovf);
            @(posedge clk); #1;
            req_valid = 1'b0; add_ovf = 1'b0;
            return;
        end
        check({tag, ".ren"}, 32'(bus_ren), 32'd1);
        check({tag, ".baddr"}, bus_addr, a & 32'hFFFF_FFFC);
        stall_cycles = stall ? 1 : 0;
        for (int i = 1; i <= k; i++) begin
            @(posedge clk); #1;
            bus_rvalid = (i == k);
            bus_rdata  = (i == k) ? rdata : $urandom;
            @(negedge clk);
            check({tag, ".wait_ren"}, 32'(bus_ren), 32'd0);
            check({tag, ".wait_vld"}, 32'(ld_valid), 32'd0);
            if (stall) stall_cycles++;
        end
        check({tag, ".stall_len"}, 32'(stall_cycles), 32'(k + 1));
        exp_data = model_ext(sel, a[1:0], rdata);
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = $urandom;
        @(negedge clk);
        check({tag, ".done_vld"}, 32'(ld_valid), 32'd1);
        check({tag, ".data"}, ld_data, exp_data);
        check({tag, ".done_stall"}, 32'(stall), 32'd0);
        check({tag, ".done_ren"}, 32'(bus_ren), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, ".post_vld"}, 32'(ld_valid), 32'd0);
        check({tag, ".hold"}, ld_data, exp_data);
        $display("load %s addr=%h sel=%0d k=%0d rdata=%h -> %h", tag, a, sel, k, rdata, ld_data);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; addr = 32'h0; load_sel = 3'd0; add_ovf = 1'b0;
        int_req = 1'b0; bus_rdata = 32'h0; bus_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.ren", 32'(bus_ren), 32'd0);
        check("rst.vld", 32'(ld_valid), 32'd0);
        check("rst.data", ld_data, 32'd0);
        reset = 1'b0;

        // Directed loads
        do_load("lw",   32'h0000_0010, 3'd0, 1'b0, 3, 32'h8765_4321);
        do_load("lb",   32'h0000_0013, 3'd3, 1'b0, 1, 32'h80AA_BBCC);
        do_load("lbu",  32'h0000_0013, 3'd4, 1'b0, 2, 32'h80AA_BBCC);
        do_load("lh",   32'h0000_0012, 3'd1, 1'b0, 1, 32'h80AA_BBCC);
        do_load("lhu",  32'h0000_0010, 3'd2, 1'b0, 4, 32'h80AA_BBCC);
        do_load("lw_m", 32'h0000_0002, 3'd0, 1'b0, 1, 32'h0);
        do_load("lh_m", 32'h0000_0001, 3'd1, 1'b0, 1, 32'h0);
        do_load("lh_io", 32'h0000_7F00, 3'd1, 1'b0, 1, 32'h0);
        do_load("lw_um", 32'h0000_5000, 3'd0, 1'b0, 1, 32'h0);
        do_load("lw_ovf", 32'h0000_0020, 3'd0, 1'b1, 1, 32'h0);
        do_load("lw_rsv", 32'h0000_0020, 3'd6, 1'b0, 1, 32'h0);
        do_load("lw_tc1", 32'h0000_7F08, 3'd0, 1'b0, 2, 32'h1234_5678);
        do_load("lw_int", 32'h0000_7F20, 3'd0, 1'b0, 1, 32'hCAFE_0001);

        // Flush request in IDLE suppresses issue
        @(posedge clk); #1;
        req_valid = 1'b1; addr = 32'h40; load_sel = 3'd0; int_req = 1'b1;
        @(negedge clk);
        check("idle_int.ren", 32'(bus_ren), 32'd0);
        check("idle_int.stall", 32'(stall), 32'd0);
        $display("idle flush: ren=%0d stall=%0d", bus_ren, stall);
        @(posedge clk); #1;
        req_valid = 1'b0; int_req = 1'b0;

        // Flush while waiting; response arrives two cycles later
        @(posedge clk); #1;
        req_valid = 1'b1; addr = 32'h10; load_sel = 3'd0;
        @(negedge clk);
        check("drain.issue", 32'(bus_ren), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; int_req = 1'b1;
        @(negedge clk);
        check("drain.int_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        int_req = 1'b0;
        @(negedge clk);
        check("drain.idle_stall", 32'(stall), 32'd0);
        check("drain.idle_ren", 32'(bus_ren), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b1; addr = 32'h24; load_sel = 3'd0;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("drain.new_stall", 32'(stall), 32'd1);
        check("drain.new_ren", 32'(bus_ren), 32'd0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        check("drain.no_vld", 32'(ld_valid), 32'd0);
        check("drain.stale", ld_data, exp_data);
        check("drain.reissue", 32'(bus_ren), 32'd1);
        check("drain.readdr", bus_addr, 32'h24);
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("drain.new_vld", 32'(ld_valid), 32'd1);
        check("drain.new_data", ld_data, 32'h0BAD_F00D);
        exp_data = 32'h0BAD_F00D;
        $display("drain sequence: ld_data=%h", ld_data);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Flush coinciding with the response: nothing left to drain
        @(posedge clk); #1;
        req_valid = 1'b1; addr = 32'h30; load_sel = 3'd0;
        @(posedge clk); #1;
        req_valid = 1'b0; int_req = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        int_req = 1'b0; bus_rvalid = 1'b0;
        req_valid = 1'b1; addr = 32'h34;
        @(negedge clk);
        check("coinc.no_vld", 32'(ld_valid), 32'd0);
        check("coinc.data", ld_data, exp_data);
        check("coinc.reissue", 32'(bus_ren), 32'd1);
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h3333_4444;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("coinc.data2", ld_data, 32'h3333_4444);
        exp_data = 32'h3333_4444;
        $display("flush+rvalid same cycle: ld_data=%h", ld_data);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Reset while waiting, then a late response
        @(posedge clk); #1;
        req_valid = 1'b1; addr = 32'h50; load_sel = 3'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstw.stall_pre", 32'(stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rstw.stall", 32'(stall), 32'd0);
        check("rstw.data", ld_data, 32'd0);
        check("rstw.vld", 32'(ld_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_data = 32'h0;
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("rstw.late_vld", 32'(ld_valid), 32'd0);
        check("rstw.late_data", ld_data, 32'd0);
        $display("reset in WAIT: ld_data=%h", ld_data);

        // Randomized loads
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [2:0]  s;
            case ($urandom_range(0, 4))
                0, 1:    a = $urandom_range(0, 32'h2FFF);
                2:       a = 32'h7F00 + $urandom_range(0, 43);
                3:       a = $urandom;
                default: a = 32'h2FFC + $urandom_range(0, 7);
            endcase
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            s = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            do_load("rnd", a, s, ($urandom_range(0, 9) == 0), $urandom_range(1, 4), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
